register_w16: RTL and testbench
===============================

# register_w16

16-bit (parameterisable) D-type pipeline register: captures `data_in` on every rising clock edge and presents it on `data_out` one cycle later. It is a general-purpose storage and retiming element, used to break timing paths and hold a word for one or more cycles between datapath stages. There is no enable and no handshake; the register reloads unconditionally on every clock.

## Interface
- `WIDTH`, default 16: data width in bits. Must be ≥ 1.
- `RESET_VALUE`, default `{WIDTH{1'b0}}`: value loaded into `data_out` while reset is asserted.

- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst_n`, input, 1: reset; one clock, asynchronous, active-low.
- `data_in`, input, WIDTH: word to capture.
- `data_out`, output, WIDTH: registered copy of `data_in`; driven directly from the flop, with no combinational path from any input.

## Operation
- Single WIDTH-bit state register `q`; `data_out = q`.
- `rst_n` low: `q` is forced to RESET_VALUE immediately, independent of `clk`.
  - Held at RESET_VALUE for as long as `rst_n` stays low.
  - `data_in` is ignored while reset is asserted.
- `rst_n` high: on each rising `clk` edge, `q <= data_in`, all bits simultaneously.
- Width rules:
  - No arithmetic, truncation or sign handling; bit i of `data_out` is bit i of the captured `data_in`.
  - RESET_VALUE is sized to WIDTH.
- No enable: a value held on `data_in` is simply recaptured each cycle. `data_out` stays stable while `data_in` is stable.
- X/Z on `data_in` at a capture edge propagates to `data_out`. No sanitising.
- Integration: `rst_n` must be driven or tied high. The block does not define behaviour for a floating reset.

## Timing
- Latency: exactly 1 clock. A value sampled at rising edge N appears on `data_out` just after edge N, and holds until edge N+1.
- Reset assertion: asynchronous. `data_out` goes to RESET_VALUE within the flop clock-to-q of the `rst_n` falling edge, with no clock needed.
- Reset deassertion: `rst_n` rising is synchronised by the integrator, not inside this block.
  - The first capture happens at the first rising `clk` edge where `rst_n` is already high.
  - If `rst_n` rises on the same edge as `clk`, that edge does not capture; the design must meet recovery/removal.
- Reset mid-stream: the current contents are lost immediately. After release, normal capture resumes on the next edge with no warm-up cycles.
- Input changes between clock edges have no effect until the next rising edge. Glitches are not visible on `data_out`.
- Setup/hold at `data_in` are the flop's own; there is no internal combinational logic ahead of the flop.

## Test plan
- **Reset:** `rst_n = 0`, `data_in = 16'hFFFF`, clock running.
  - Required: `data_out == 16'h0000` throughout.
  - Required: `data_out` returns to 0 within the same timestep as a `rst_n` falling edge, with no clock edge needed.
- **Basic capture:** release reset, then drive `data_in` on falling edges as 16'h0005, 16'h000A, 16'h0003, one per cycle.
  - Required: `data_out` equals 0005, 000A, 0003 after the following rising edges, each exactly one cycle after it is driven.
- **Hold:** keep `data_in = 16'h0003` for 10 cycles.
  - Required: `data_out` stays 16'h0003 with no transitions.
- **Mid-cycle change:** change `data_in` from 16'h1234 to 16'hABCD between edges, then back to 16'h1234 before the next rising edge.
  - Required: `data_out` never shows 16'hABCD.
- **Reset mid-operation:** with `data_out = 16'hBEEF`, pulse `rst_n` low for 3 ns between clock edges.
  - Required: `data_out` goes to 0 immediately.
  - Required: after release, the next rising edge loads the current `data_in`, e.g. 16'h5A5A.
- **Full-width patterns:** apply 16'hAAAA, 16'h5555, 16'h8001, 16'h0000 on successive cycles.
  - Required: each appears bit-exact on `data_out` one cycle later, proving there is no bit swap or truncation.

Source files
------------

// File: rtl/register_w16_if.sv
// Purpose: data bundle for the register_w16 pipeline register (word in, word out).
// Latency: n/a (wires only); the register behind it adds exactly one clock.
// Backpressure: none; no valid/ready, the consumer sees a new word every clock.
// Ports: data_in  - word to be captured (master drives)
//        data_out - registered copy of data_in (slave drives)
interface register_w16_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;

  // Upstream side: supplies the word, observes the registered copy.
  modport master (
    output data_in,
    input  data_out
  );

  // Register side: consumes the word, drives the registered copy.
  modport slave (
    input  data_in,
    output data_out
  );
endinterface

// File: rtl/register_w16.sv
// Purpose: WIDTH-bit D-type pipeline register for retiming / breaking timing paths.
// Latency: 1 clock; reloads unconditionally on every rising clk edge.
// Backpressure: none; no enable or handshake, a held input is recaptured each cycle.
// Ports: clk      - single clock, rising edge
//        rst_n    - asynchronous active-low reset, forces data_out to RESET_VALUE
//        bus      - slave modport: data_in (captured word), data_out (flop output)
module register_w16 #(
  parameter int unsigned      WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic          clk,
  input  logic          rst_n,
  register_w16_if.slave bus
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  // Straight bit-for-bit pass-through: nothing sits ahead of the flop, so the
  // input setup/hold window is the flop's own.
  always_comb begin
    data_d = bus.data_in;
  end

  // Reset is asynchronous on assertion; release is expected to be synchronised
  // upstream, so an edge coinciding with rst_n rising does not capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= RESET_VALUE;
    end else begin
      data_q <= data_d;
    end
  end

  // Output comes straight from the flop; no combinational path from any input.
  assign bus.data_out = data_q;

endmodule

// File: tb/tb_register_w16.sv
module tb_register_w16;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] din;
    logic [W-1:0] exp;
  } vec_t;

  logic clk;
  logic rst_n;

  register_w16_if #(.WIDTH(W)) bus ();

  register_w16 #(.WIDTH(W), .RESET_VALUE({W{1'b0}})) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           checks;
  int           errors;
  logic [W-1:0] exp_q[$];
  vec_t         tbl[7];

  // Output activity monitor used by the hold and mid-cycle sequences.
  int   n_trans;
  logic saw_abcd;
  initial begin
    n_trans  = 0;
    saw_abcd = 1'b0;
  end
  always @(bus.data_out) begin
    n_trans = n_trans + 1;
    if (bus.data_out === 16'hABCD) saw_abcd = 1'b1;
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive a word on the falling edge, record its expectation, then compare
  // just after the following rising edge against the scoreboard head.
  task automatic cycle(input string name, input logic [W-1:0] din, input logic [W-1:0] exp);
    @(negedge clk);
    bus.data_in = din;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL %s: scoreboard empty, got %h", name, bus.data_out);
    end else begin
      check(name, bus.data_out, exp_q.pop_front());
    end
  endtask

  // Safety net against a hung run.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;

    tbl[0] = '{din: 16'h0005, exp: 16'h0005};
    tbl[1] = '{din: 16'h000A, exp: 16'h000A};
    tbl[2] = '{din: 16'h0003, exp: 16'h0003};
    tbl[3] = '{din: 16'hAAAA, exp: 16'hAAAA};
    tbl[4] = '{din: 16'h5555, exp: 16'h5555};
    tbl[5] = '{din: 16'h8001, exp: 16'h8001};
    tbl[6] = '{din: 16'h0000, exp: 16'h0000};

    // Reset: assert with no clock edge in between, data_in all ones.
    rst_n       = 1'b1;
    bus.data_in = 16'hFFFF;
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async", bus.data_out, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_held", bus.data_out, 16'h0000);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Basic capture.
    for (int i = 0; i < 3; i++) cycle("basic_capture", tbl[i].din, tbl[i].exp);

    // Hold 0003 for 10 cycles: output must never move.
    n_trans = 0;
    for (int i = 0; i < 10; i++) cycle("hold", 16'h0003, 16'h0003);
    checks = checks + 1;
    if (n_trans != 0) begin
      errors = errors + 1;
      $display("FAIL hold_transitions: got %0d expected 0", n_trans);
    end

    // Mid-cycle glitch on data_in between edges.
    cycle("midcycle_pre", 16'h1234, 16'h1234);
    saw_abcd    = 1'b0;
    #1;
    bus.data_in = 16'hABCD;
    #1;
    check("midcycle_between", bus.data_out, 16'h1234);
    #1;
    bus.data_in = 16'h1234;
    @(posedge clk);
    #1;
    check("midcycle_after", bus.data_out, 16'h1234);
    checks = checks + 1;
    if (saw_abcd) begin
      errors = errors + 1;
      $display("FAIL midcycle_glitch: got ABCD on data_out expected never");
    end

    // Reset mid-operation: 3 ns low pulse between edges.
    cycle("midreset_load", 16'hBEEF, 16'hBEEF);
    #1;                       // posedge + 2
    bus.data_in = 16'h5A5A;
    rst_n       = 1'b0;
    #1;
    check("midreset_async", bus.data_out, 16'h0000);
    #2;                       // posedge + 5
    rst_n = 1'b1;
    #1;
    check("midreset_released", bus.data_out, 16'h0000);
    @(posedge clk);
    #1;
    check("midreset_first_capture", bus.data_out, 16'h5A5A);

    // Full-width patterns.
    for (int i = 3; i < 7; i++) cycle("full_width", tbl[i].din, tbl[i].exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
